// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry valid/ready output register and error pulses.
// Define UART_RX_PARITY_EN to receive an even-parity bit between bit 7 and the stop bit.
module uart_rx #(
  parameter int FREQ = 27000000,
  parameter int BAUD = 115200
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       uart_rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       overrun_o
);

  localparam int CPB   = FREQ / BAUD;
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = $clog2(CPB);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CPB_M1  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  generate
    if (CPB < 4) begin : g_cpb_check
      $error("uart_rx: FREQ/BAUD must be at least 4");
    end
  endgenerate

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       idx, idx_nx;
  logic [7:0]       shift, shift_nx;
  logic             rx_meta_p0, rx_s;
  logic             byte_done, frame_set, parity_set;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_nx;
`endif

  // Stage p0/p1: two-flop synchronizer, idle-high
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_meta_p0 <= 1'b1;
      rx_s       <= 1'b1;
    end else begin
      rx_meta_p0 <= uart_rx_i;
      rx_s       <= rx_meta_p0;
    end
  end

  // Control state: FSM, bit-period counter, bit index
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
    end
  end

  // Data-only registers; a reset mid-frame simply abandons their contents
  always_ff @(posedge clk_i) begin
    shift <= shift_nx;
`ifdef UART_RX_PARITY_EN
    par_q <= par_nx;
`endif
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt + CNT_ONE;
    idx_nx     = idx;
    shift_nx   = shift;
    byte_done  = 1'b0;
    frame_set  = 1'b0;
    parity_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_nx     = par_q;
`endif
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (!rx_s) state_nx = START;
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_nx   = '0;
          idx_nx   = '0;
          state_nx = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CPB_M1) begin
          cnt_nx        = '0;
          shift_nx[idx] = rx_s;
          idx_nx        = idx + 3'd1;
          if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nx = PARITY;
`else
            state_nx = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == CPB_M1) begin
          cnt_nx   = '0;
          par_nx   = rx_s;
          state_nx = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt == CPB_M1) begin
          cnt_nx = '0;
          if (rx_s) begin
            state_nx = IDLE;
`ifdef UART_RX_PARITY_EN
            // Even parity: data bits and parity bit together must XOR to zero
            if ((^shift) ^ par_q) parity_set = 1'b1;
            else                  byte_done  = 1'b1;
`else
            byte_done = 1'b1;
`endif
          end else begin
            // Framing error outranks a parity error on the same frame
            frame_set = 1'b1;
            state_nx  = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_nx = '0;
        if (rx_s) state_nx = IDLE;
      end
      default: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

  // Output register stage: one-entry holding register plus single-cycle pulses
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      data_o      <= 8'h00;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= frame_set;
      overrun_o   <= byte_done && valid_o && !ready_i;
      if (byte_done && (!valid_o || ready_i)) begin
        data_o  <= shift;
        valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) parity_err_o <= 1'b0;
    else         parity_err_o <= parity_set;
  end
`else
  assign parity_err_o = 1'b0;
  logic unused_parity;
  assign unused_parity = parity_set;
`endif

endmodule

// File: doc/uart_rx.md
# uart_rx

Synthesizable 8N1 UART receiver driving `top`'s `uart_rx_i` path. It is the receiving end of the serial link the design already transmits on. It deserializes the line into bytes and holds each byte in a one-entry output register under a valid/ready handshake. Framing errors and overruns are flagged as one-cycle pulses.

## Interface
- `FREQ`, default 27000000: clock frequency in Hz; simulation uses 460800.
- `BAUD`, default 115200: line rate in bit/s.
- `clk_i`  in  1  system clock; all logic is on the rising edge.
- `rstn_i`  in  1  asynchronous active-low reset.
- `uart_rx_i`  in  1  serial line; idle high; asynchronous to `clk_i`.
- `data_o`  out  8  received byte; stable while `valid_o`=1.
- `valid_o`  out  1  byte available.
- `ready_i`  in  1  consumer accepts `data_o` when `valid_o && ready_i`.
- `frame_err_o`  out  1  one-cycle pulse: stop bit sampled low.
- `parity_err_o`  out  1  one-cycle pulse: parity mismatch; constant 0 without the macro.
- `overrun_o`  out  1  one-cycle pulse: completed byte dropped because the output register was full.

## Operation
- Derived constants:
  - `CPB = FREQ/BAUD`, integer division; elaboration fails if `CPB < 4`.
  - `HALF = CPB/2`.
  - Bit counter width: `$clog2(CPB)`.
- Input path: 2-flop synchronizer, both stages reset to 1. The FSM sees only the synchronized value `rx_s`.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
- IDLE:
  - On `rx_s`=0, go to START with cycle counter = 0.
- START:
  - When counter = `HALF-1`, sample `rx_s`.
  - Sample = 1 is a false start: return to IDLE with no pulse.
  - Sample = 0: go to DATA with counter = 0 and bit index = 0.
- DATA:
  - When counter = `CPB-1`, sample `rx_s` into shift register bit `index`. Bits arrive LSB first.
  - Counter resets to 0 on every sample.
  - After index 7, go to STOP (or PARITY when the macro is defined).
- STOP:
  - When counter = `CPB-1`, sample `rx_s`.
  - Sample = 1: byte completes; go to IDLE.
  - Sample = 0: pulse `frame_err_o`, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH:
  - Stay until `rx_s`=1, then go to IDLE. A break condition produces exactly one `frame_err_o`.
- Output register on byte completion:
  - `valid_o`=0, or `valid_o && ready_i` in the same cycle: load `data_o` and set `valid_o`=1.
  - `valid_o && !ready_i`: keep the old byte, drop the new one, pulse `overrun_o`.
- Handshake:
  - `valid_o && ready_i` with no completion in that cycle clears `valid_o` next cycle.
  - `data_o` keeps its last value after acceptance.
- The receiver never stalls. The line is always sampled regardless of `ready_i`.
- Reset (asserted at any time, including mid-frame):
  - FSM returns to IDLE; synchronizer flops go to 1.
  - `data_o`=0x00, `valid_o`=0, `frame_err_o`=0, `parity_err_o`=0, `overrun_o`=0.
  - The partial byte is lost.

## Timing
- Pin-to-FSM latency: 2 cycles.
- Start detection to first data sample: `HALF + CPB` cycles. Data bit k is sampled `HALF + (k+1)·CPB` cycles after IDLE sees `rx_s`=0.
- `valid_o`, `frame_err_o`, `parity_err_o` and `overrun_o` go high on the clock edge after the decisive sample cycle.
- Pulses last exactly 1 cycle.
- Back-to-back frames:
  - The FSM is in IDLE on the cycle after the stop sample.
  - A start edge arriving half a bit after the stop sample is still caught.
  - No dead time beyond 1 cycle.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - One even-parity bit follows bit 7, sampled at counter = `CPB-1` in PARITY.
  - Parity check: XOR of the 8 data bits and the parity bit must be 0.
  - On mismatch the FSM still checks the stop bit. If the stop bit is 1, pulse `parity_err_o` and discard the byte. If the stop bit is 0, `frame_err_o` takes precedence and only it pulses.
  - Frame is 11 bits.
- `UART_RX_PARITY_EN` undefined:
  - No PARITY state; 8N1 frame of 10 bits.
  - `parity_err_o` tied to 0.

## Test plan
All scenarios use `FREQ`=460800 and `BAUD`=115200, so `CPB`=4.
- Reset, then line idle for 100 cycles -> all outputs 0, `data_o`=0x00.
- Send frame 0x55 with `ready_i`=1 -> `valid_o` high 1 cycle with `data_o`=0x55; no error pulses.
- Send 0xA5 then 0x3C back-to-back with `ready_i`=0, then raise `ready_i` -> `data_o`=0xA5 is held; one `overrun_o` pulse at the 0x3C stop sample; after the handshake `valid_o`=0.
- Send 0x81 with the stop bit driven low, line held low 20 more cycles, then high; then send 0x7E -> one `frame_err_o`, no valid for 0x81; `data_o`=0x7E valid afterwards.
- Drive the line low for 1 cycle only -> false start rejected; no outputs change.
- Assert `rstn_i` low during bit 4 of 0xF0, then send 0x0F -> outputs reset immediately; only 0x0F is delivered. With the macro defined, 0x0F sent with the wrong parity bit -> `parity_err_o` pulse, no valid.
